// File: rtl/vj_std_dev_pkg.sv
// Shared FSM type, default geometry and the variance clamp for the window std-dev path.
// The window edge defaults to 24 and is overridable through the top-level parameter.
package vj_std_dev_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_VAR,
        S_SQRT,
        S_DONE
    } state_t;

    localparam int DEF_WINDOW_SIZE = 24;

    localparam int DEF_II_W   = 32;
    localparam int DEF_AREA   = DEF_WINDOW_SIZE * DEF_WINDOW_SIZE;
    localparam int DEF_VAR_W  = 2 * DEF_II_W;
    localparam int DEF_RES_W  = DEF_VAR_W / 2;
    localparam int DEF_PROD_W = 2 * DEF_II_W + $clog2(DEF_AREA) + 1;
    localparam int CLAMP_W    = 128;

    // Negative variance floors to zero, oversize variance saturates to var_w ones.
    function automatic logic [CLAMP_W-1:0] clamp_var(
        input logic signed [CLAMP_W-1:0] t,
        input int                        var_w
    );
        logic [CLAMP_W-1:0] lim;
        lim = (CLAMP_W'(1) << var_w) - CLAMP_W'(1);
        if (t < 0) return '0;
        if ($unsigned(t) > lim) return lim;
        return $unsigned(t);
    endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Restoring digit-by-digit integer square root, one result bit per clock.
// o_done marks the final iteration while o_busy is high; o_root is valid with it.
module isqrt_iter #(
    parameter int VAR_W = 64,
    parameter int RES_W = VAR_W / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [VAR_W-1:0] i_radicand,
    output logic             o_busy,
    output logic             o_done,
    output logic [RES_W-1:0] o_root
);

    localparam int CNT_W = $clog2(RES_W + 1);
    localparam int REM_W = RES_W + 2;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [VAR_W-1:0] r_op;
    logic [REM_W-1:0] r_rem;
    logic [RES_W-1:0] r_root;

    logic [REM_W-1:0] w_rem_sh;
    logic [REM_W-1:0] w_trial;
    logic [REM_W-1:0] w_diff;
    logic             w_fit;
    logic [RES_W-1:0] w_root_nxt;
    logic             w_unused;

    // The remainder never needs more than RES_W bits before a shift.
    assign w_rem_sh   = {r_rem[RES_W-1:0], r_op[VAR_W-1 -: 2]};
    assign w_trial    = {r_root, 2'b01};
    assign w_fit      = (w_rem_sh >= w_trial);
    assign w_diff     = w_fit ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = {r_root[RES_W-2:0], w_fit};
    assign w_unused   = ^r_rem[REM_W-1:RES_W];

    assign o_busy = r_busy;
    assign o_done = (r_cnt == '0);
    assign o_root = w_root_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_rem  <= '0;
            r_root <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(RES_W - 1);
            r_op   <= i_radicand;
            r_rem  <= '0;
            r_root <= '0;
        end else if (r_busy) begin
            r_op   <= {r_op[VAR_W-3:0], 2'b00};
            r_rem  <= w_diff;
            r_root <= w_root_nxt;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/window_std_dev_seq.sv
// Sequential window std-dev: corner deltas, clamped AREA*sum_sq - sum^2, serial root.
// Define WIN_STD_DEV_FLAT_EN to add flat_win and force std_dev to 1 on flat windows.
module window_std_dev_seq
    import vj_std_dev_pkg::*;
#(
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int II_W        = DEF_II_W,
    parameter int VAR_W       = 2 * II_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [II_W-1:0] ii_tl,
    input  logic [II_W-1:0] ii_tr,
    input  logic [II_W-1:0] ii_bl,
    input  logic [II_W-1:0] ii_br,
    input  logic [II_W-1:0] sq_tl,
    input  logic [II_W-1:0] sq_tr,
    input  logic [II_W-1:0] sq_bl,
    input  logic [II_W-1:0] sq_br,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [II_W-1:0] std_dev
`ifdef WIN_STD_DEV_FLAT_EN
    ,
    output logic            flat_win
`endif
);

    localparam int AREA   = WINDOW_SIZE * WINDOW_SIZE;
    localparam int RES_W  = VAR_W / 2;
    localparam int PROD_W = 2 * II_W + $clog2(AREA) + 1;

    state_t          r_state;
    state_t          w_next;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [II_W-1:0] r_std_dev;
    logic [II_W-1:0] r_tl, r_tr, r_bl, r_br;
    logic [II_W-1:0] r_qtl, r_qtr, r_qbl, r_qbr;
    logic [II_W-1:0] r_sum, r_sum_sq;
    logic            r_var_zero;

    logic                     w_accept;
    logic                     w_start;
    logic                     w_sq_busy;
    logic                     w_sq_done;
    logic                     w_sq_fin;
    logic                     w_out_acc;
    logic signed [PROD_W-1:0] w_t;
    logic [VAR_W-1:0]         w_var;
    logic [RES_W-1:0]         w_root;

`ifdef WIN_STD_DEV_FLAT_EN
    localparam logic FLAT_EN = 1'b1;
`else
    localparam logic FLAT_EN = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign std_dev   = r_std_dev;

    assign w_accept  = r_in_ready && in_valid;
    assign w_start   = (r_state == S_VAR);
    assign w_sq_fin  = (r_state == S_SQRT) && w_sq_busy && w_sq_done;
    assign w_out_acc = r_out_valid && out_ready;

    // Full-width modular arithmetic; the true result always fits signed PROD_W.
    assign w_t   = $signed(PROD_W'(AREA) * PROD_W'(r_sum_sq)
                 - PROD_W'(r_sum) * PROD_W'(r_sum));
    assign w_var = VAR_W'(clamp_var(CLAMP_W'(w_t), VAR_W));

    isqrt_iter #(
        .VAR_W (VAR_W),
        .RES_W (RES_W)
    ) u_isqrt (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_start),
        .i_radicand (w_var),
        .o_busy     (w_sq_busy),
        .o_done     (w_sq_done),
        .o_root     (w_root)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SUM;
            S_SUM:   w_next = S_VAR;
            S_VAR:   w_next = S_SQRT;
            S_SQRT:  if (w_sq_fin) w_next = S_DONE;
            S_DONE:  if (w_out_acc) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_std_dev   <= '0;
            r_tl        <= '0;
            r_tr        <= '0;
            r_bl        <= '0;
            r_br        <= '0;
            r_qtl       <= '0;
            r_qtr       <= '0;
            r_qbl       <= '0;
            r_qbr       <= '0;
            r_sum       <= '0;
            r_sum_sq    <= '0;
            r_var_zero  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_tl  <= ii_tl;
                r_tr  <= ii_tr;
                r_bl  <= ii_bl;
                r_br  <= ii_br;
                r_qtl <= sq_tl;
                r_qtr <= sq_tr;
                r_qbl <= sq_bl;
                r_qbr <= sq_br;
            end
            if (r_state == S_SUM) begin
                r_sum    <= r_br - r_bl + r_tl - r_tr;
                r_sum_sq <= r_qbr - r_qbl + r_qtl - r_qtr;
            end
            if (r_state == S_VAR) r_var_zero <= (w_var == '0);
            if (w_sq_fin) begin
                r_out_valid <= 1'b1;
                r_std_dev   <= (FLAT_EN && r_var_zero) ? II_W'(1) : II_W'(w_root);
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef WIN_STD_DEV_FLAT_EN
    logic r_flat;

    assign flat_win = r_flat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_flat <= 1'b0;
        else if (w_sq_fin)  r_flat <= r_var_zero;
        else if (w_out_acc) r_flat <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_window_std_dev_seq.sv
// Directed and random bench for window_std_dev_seq against an arithmetic reference.
// Honours WIN_STD_DEV_FLAT_EN in the same way as the design.
module tb_window_std_dev_seq;

    localparam int AREA = 24 * 24;
    localparam int LAT  = 34;
`ifdef WIN_STD_DEV_FLAT_EN
    localparam bit FLAT = 1'b1;
`else
    localparam bit FLAT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] ii_tl = '0, ii_tr = '0, ii_bl = '0, ii_br = '0;
    logic [31:0] sq_tl = '0, sq_tr = '0, sq_bl = '0, sq_br = '0;
    logic [31:0] std_dev;
`ifdef WIN_STD_DEV_FLAT_EN
    logic        flat_win;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    window_std_dev_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ii_tl     (ii_tl),
        .ii_tr     (ii_tr),
        .ii_bl     (ii_bl),
        .ii_br     (ii_br),
        .sq_tl     (sq_tl),
        .sq_tr     (sq_tr),
        .sq_bl     (sq_bl),
        .sq_br     (sq_br),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .std_dev   (std_dev)
`ifdef WIN_STD_DEV_FLAT_EN
        ,
        .flat_win  (flat_win)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: wrapped corner sums, exact variance, clamp, largest r with r*r <= var.
    function automatic logic [31:0] ref_std(
        input logic [31:0] tl, tr, bl, br, qtl, qtr, qbl, qbr,
        output bit         is_flat
    );
        logic [31:0]  s, q;
        logic [127:0] t, v, lo, hi, mid;
        s = br - bl + tl - tr;
        q = qbr - qbl + qtl - qtr;
        t = 128'(AREA) * {96'd0, q} - {96'd0, s} * {96'd0, s};
        if (t[127]) v = '0;
        else if (t > 128'hFFFF_FFFF_FFFF_FFFF) v = 128'hFFFF_FFFF_FFFF_FFFF;
        else v = t;
        lo = '0;
        hi = 128'hFFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        is_flat = (v == '0);
        if (FLAT && is_flat) return 32'd1;
        return lo[31:0];
    endfunction

    task automatic send(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        int w;
        ii_tl = a0; ii_tr = a1; ii_bl = a2; ii_br = a3;
        sq_tl = b0; sq_tr = b1; sq_bl = b2; sq_br = b3;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        ii_tl = $urandom; ii_tr = $urandom; ii_bl = $urandom; ii_br = $urandom;
        sq_tl = $urandom; sq_tr = $urandom; sq_bl = $urandom; sq_br = $urandom;
    endtask

    task automatic run(
        input string       tag,
        input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3,
        input logic [31:0] exp,
        input bit          exp_flat,
        input int          hold,
        input bit          poke
    );
        int lat;
        send(a0, a1, a2, a3, b0, b1, b2, b3);
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (poke) in_valid = lat[0];
            @(posedge clock); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_std_dev"}, 64'(std_dev), 64'(exp));
`ifdef WIN_STD_DEV_FLAT_EN
        check({tag, "_flat_win"}, 64'(flat_win), 64'(exp_flat));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(std_dev), 64'(exp));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c [8];
        logic [31:0] e;
        logic [31:0] s, q;
        longint      sl, lo;
        bit          f;
        int          extra;

        repeat (3) begin
            @(posedge clock); #1;
            check("reset_in_ready", 64'(in_ready), 64'd0);
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_std_dev", 64'(std_dev), 64'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        run("uniform", 0, 0, 0, 5760, 0, 0, 0, 57600, FLAT ? 32'd1 : 32'd0, 1'b1, 0, 1'b0);
        run("half", 0, 0, 0, 5760, 0, 0, 0, 115200, 32'd5760, 1'b0, 0, 1'b0);
        run("nonperfect", 0, 0, 0, 0, 0, 0, 0, 2, 32'd33, 1'b0, 0, 1'b0);
        run("wrap", 32'hFFFF_FFF0, 0, 0, 32'h10, 0, 0, 0, 1, 32'd24, 1'b0, 0, 1'b0);
        run("negclamp", 0, 0, 0, 1, 0, 0, 0, 0, FLAT ? 32'd1 : 32'd0, 1'b1, 0, 1'b0);

        run("backpressure", 0, 0, 0, 5760, 0, 0, 0, 115200, 32'd5760, 1'b0, 5, 1'b1);
        extra = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) extra++;
        end
        check("no_extra_result", 64'(extra), 64'd0);

        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 3) begin
                for (int j = 0; j < 8; j++) c[j] = $urandom;
            end else begin
                s  = $urandom_range(0, AREA * 255);
                sl = longint'(s);
                lo = (sl * sl + AREA - 1) / AREA;
                if (k % 4 == 2) q = (lo > 0) ? 32'(lo - 1) : 32'd0;
                else q = 32'(lo + longint'($urandom_range(0, 3000000)));
                c[0] = $urandom; c[1] = $urandom; c[2] = $urandom;
                c[3] = s + c[2] + c[1] - c[0];
                c[4] = $urandom; c[5] = $urandom; c[6] = $urandom;
                c[7] = q + c[6] + c[5] - c[4];
            end
            e = ref_std(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], f);
            run("random", c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7],
                e, f, $urandom_range(0, 2), 1'b0);
        end

        send(0, 0, 0, 5760, 0, 0, 0, 115200);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_midreset", 64'(in_ready), 64'd1);
        extra = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) extra++;
        end
        check("midreset_no_result", 64'(extra), 64'd0);
        c[0] = 7; c[1] = 3; c[2] = 100; c[3] = 2000;
        c[4] = 11; c[5] = 5; c[6] = 900; c[7] = 90000;
        e = ref_std(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], f);
        run("after_midreset", c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], e, f, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
